// File: rtl/gpio_pkg.sv
// Shared definitions for the memory-mapped GPIO block: register offsets
// within the 32-byte window and the window size.
package gpio_pkg;

   localparam int GPIO_WIN_BITS = 5;

   typedef enum logic [2:0] {
      REG_DIR      = 3'd0,
      REG_OUT      = 3'd1,
      REG_IN       = 3'd2,
      REG_IRQ_EN   = 3'd3,
      REG_IRQ_STAT = 3'd4,
      REG_EDGE_SEL = 3'd5,
      REG_OUT_SET  = 3'd6,
      REG_OUT_CLR  = 3'd7
   } gpio_reg_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser: NUM_PINS independent chains, each
// SYNC_STAGES flops deep, cleared by the asynchronous reset.
module gpio_sync #(
   parameter int NUM_PINS    = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_PINS-1:0] d_i,
   output logic [NUM_PINS-1:0] q_o
);

   logic [NUM_PINS-1:0] stage_q [SYNC_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO peripheral with per-pin direction, synchronised inputs
// and edge interrupts (W1C status). GPIO_SET_CLR_EN adds OUT_SET/OUT_CLR.
module gpio_mmio
   import gpio_pkg::*;
#(
   parameter int          NUM_PINS    = 32,
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                write_mem,
   input  logic                read_mem,
   input  logic [31:0]         data_address,
   input  logic [31:0]         data_to_write,
   input  logic [31:0]         data_from_mem,
   output logic [31:0]         data_read,
   input  logic [NUM_PINS-1:0] gpio_in,
   output logic [NUM_PINS-1:0] gpio_out,
   output logic [NUM_PINS-1:0] gpio_oe,
   output logic                irq
);

   localparam int WARM_MAX = SYNC_STAGES + 1;

   logic [NUM_PINS-1:0] dir_q, dir_d;
   logic [NUM_PINS-1:0] out_q, out_d;
   logic [NUM_PINS-1:0] irq_en_q, irq_en_d;
   logic [NUM_PINS-1:0] stat_q, stat_d;
   logic [NUM_PINS-1:0] edge_sel_q, edge_sel_d;
   logic [NUM_PINS-1:0] prev_q;
   logic [NUM_PINS-1:0] gpio_out_q, gpio_oe_q;
   logic [NUM_PINS-1:0] in_sync, wdata, w1c_mask, rise, fall, ev;
   logic [2:0]          warm_q;
   logic                irq_q;
   logic                hit, wr_hit, rd_hit, warm_done;
   gpio_reg_e           reg_off;
   logic [31:0]         rdata;

   gpio_sync #(
      .NUM_PINS    (NUM_PINS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (gpio_in),
      .q_o (in_sync)
   );

   assign hit     = (data_address[31:GPIO_WIN_BITS] == BASE_ADDR[31:GPIO_WIN_BITS]) &&
                    (data_address[1:0] == 2'b00);
   assign wr_hit  = write_mem & hit;
   assign rd_hit  = read_mem & ~write_mem & hit;
   assign reg_off = gpio_reg_e'(data_address[4:2]);
   assign wdata   = data_to_write[NUM_PINS-1:0];

   // Events stay masked until the synchroniser and prev have flushed reset-time zeros.
   assign warm_done = (warm_q == 3'(WARM_MAX));
   assign rise      = in_sync & ~prev_q;
   assign fall      = ~in_sync & prev_q;
   assign ev        = ((edge_sel_q & rise) | (~edge_sel_q & fall)) & ~dir_q &
                      {NUM_PINS{warm_done}};

   always_comb begin
      dir_d      = dir_q;
      out_d      = out_q;
      irq_en_d   = irq_en_q;
      edge_sel_d = edge_sel_q;
      w1c_mask   = '0;
      if (wr_hit) begin
         case (reg_off)
            REG_DIR:      dir_d      = wdata;
            REG_OUT:      out_d      = wdata;
            REG_IRQ_EN:   irq_en_d   = wdata;
            REG_IRQ_STAT: w1c_mask   = wdata;
            REG_EDGE_SEL: edge_sel_d = wdata;
            REG_OUT_SET: begin
`ifdef GPIO_SET_CLR_EN
               out_d = out_q | wdata;
`endif
            end
            REG_OUT_CLR: begin
`ifdef GPIO_SET_CLR_EN
               out_d = out_q & ~wdata;
`endif
            end
            default: ;
         endcase
      end
      // A fresh event beats a simultaneous clear of the same bit.
      stat_d = (stat_q & ~w1c_mask) | ev;
   end

   always_comb begin
      rdata = '0;
      case (reg_off)
         REG_DIR:      rdata[NUM_PINS-1:0] = dir_q;
         REG_OUT:      rdata[NUM_PINS-1:0] = out_q;
         REG_IN:       rdata[NUM_PINS-1:0] = in_sync;
         REG_IRQ_EN:   rdata[NUM_PINS-1:0] = irq_en_q;
         REG_IRQ_STAT: rdata[NUM_PINS-1:0] = stat_q;
         REG_EDGE_SEL: rdata[NUM_PINS-1:0] = edge_sel_q;
         default:      rdata = '0;
      endcase
   end

   assign data_read = rd_hit ? rdata : data_from_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q      <= '0;
         out_q      <= '0;
         irq_en_q   <= '0;
         stat_q     <= '0;
         edge_sel_q <= '0;
         prev_q     <= '0;
         gpio_out_q <= '0;
         gpio_oe_q  <= '0;
         warm_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         dir_q      <= dir_d;
         out_q      <= out_d;
         irq_en_q   <= irq_en_d;
         stat_q     <= stat_d;
         edge_sel_q <= edge_sel_d;
         prev_q     <= in_sync;
         gpio_out_q <= out_d & dir_d;
         gpio_oe_q  <= dir_d;
         warm_q     <= warm_done ? warm_q : warm_q + 3'd1;
         irq_q      <= |(stat_d & irq_en_d);
      end
   end

   assign gpio_out = gpio_out_q;
   assign gpio_oe  = gpio_oe_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_mmio.sv
// Scoreboard bench for gpio_mmio: directed scenarios plus randomized bus and
// pin traffic against a register-level reference model.
module tb_gpio_mmio;

   localparam int          NP   = 32;
   localparam logic [31:0] BASE = 32'hFFFF_FF00;
   localparam int          SS   = 2;
   localparam logic [31:0] PIN_MASK = 32'((64'd1 << NP) - 64'd1);
`ifdef GPIO_SET_CLR_EN
   localparam bit SETCLR = 1'b1;
`else
   localparam bit SETCLR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          write_mem = 1'b0;
   logic          read_mem = 1'b0;
   logic [31:0]   data_address = '0;
   logic [31:0]   data_to_write = '0;
   logic [31:0]   data_from_mem = '0;
   logic [31:0]   data_read;
   logic [NP-1:0] gpio_in = '0;
   logic [NP-1:0] gpio_out;
   logic [NP-1:0] gpio_oe;
   logic          irq;

   gpio_mmio #(
      .NUM_PINS    (NP),
      .BASE_ADDR   (BASE),
      .SYNC_STAGES (SS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .write_mem     (write_mem),
      .read_mem      (read_mem),
      .data_address  (data_address),
      .data_to_write (data_to_write),
      .data_from_mem (data_from_mem),
      .data_read     (data_read),
      .gpio_in       (gpio_in),
      .gpio_out      (gpio_out),
      .gpio_oe       (gpio_oe),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   typedef enum int {K_RD, K_OUT, K_OE, K_IRQ} kind_e;
   typedef struct {
      kind_e       kind;
      string       name;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       n_checks = 0;
   int       n_fail = 0;
   logic     probe = 1'b0;
   logic     done = 1'b0;

   // Reference model: architectural register contents and current pad levels.
   logic [31:0] m_dir, m_out, m_en, m_stat, m_esel, m_pins;

   function automatic logic is_hit(logic [31:0] a);
      return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] ra(int off);
      return BASE + 32'(off * 4);
   endfunction

   function automatic logic [31:0] model_reg(int off);
      case (off)
         0: return m_dir & PIN_MASK;
         1: return m_out & PIN_MASK;
         2: return m_pins & PIN_MASK;
         3: return m_en & PIN_MASK;
         4: return m_stat & PIN_MASK;
         5: return m_esel & PIN_MASK;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_dir = '0; m_out = '0; m_en = '0; m_stat = '0; m_esel = '0;
   endtask

   task automatic model_write(logic [31:0] a, logic [31:0] d);
      logic [31:0] v;
      v = d & PIN_MASK;
      if (is_hit(a)) begin
         case (int'(a[4:2]))
            0: m_dir = v;
            1: m_out = v;
            3: m_en = v;
            4: m_stat = m_stat & ~v;
            5: m_esel = v;
            6: if (SETCLR) m_out = m_out | v;
            7: if (SETCLR) m_out = m_out & ~v;
            default: ;
         endcase
      end
   endtask

   // Monitor: on every probed cycle, drain and compare all pending expectations.
   always @(negedge clk) begin : monitor
      sb_item_t    it;
      logic [31:0] act;
      if (probe) begin
         while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.kind)
               K_RD:    act = data_read;
               K_OUT:   act = 32'(gpio_out);
               K_OE:    act = 32'(gpio_oe);
               default: act = {31'd0, irq};
            endcase
            n_checks++;
            if (act !== it.exp) begin
               n_fail++;
               $display("FAIL %s: got %h, expected %h", it.name, act, it.exp);
            end else begin
               $display("ok   %s: %h", it.name, act);
            end
         end
      end
      if (done) begin
         n_checks++;
         if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d items pending, expected 0", sb_q.size());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic push(kind_e k, string nm, logic [31:0] v);
      sb_item_t it;
      it.kind = k;
      it.name = nm;
      it.exp  = v;
      sb_q.push_back(it);
   endtask

   task automatic wr(logic [31:0] a, logic [31:0] d, logic with_rd);
      data_from_mem = $urandom;
      data_address  = a;
      data_to_write = d;
      write_mem     = 1'b1;
      read_mem      = with_rd;
      push(K_RD, "wr_passthru", data_from_mem);
      probe = 1'b1;
      tick();
      write_mem = 1'b0;
      read_mem  = 1'b0;
      probe     = 1'b0;
      model_write(a, d);
   endtask

   task automatic rd_dfm(logic [31:0] a, logic [31:0] dfm, logic [31:0] exp, string nm);
      data_from_mem = dfm;
      data_address  = a;
      read_mem      = 1'b1;
      push(K_RD, nm, exp);
      probe = 1'b1;
      tick();
      read_mem = 1'b0;
      probe    = 1'b0;
   endtask

   task automatic rd(logic [31:0] a, logic [31:0] exp, string nm);
      rd_dfm(a, $urandom, exp, nm);
   endtask

   task automatic check_pins(string nm);
      push(K_OE, {nm, "_oe"}, m_dir & PIN_MASK);
      push(K_OUT, {nm, "_out"}, m_out & m_dir & PIN_MASK);
      push(K_IRQ, {nm, "_irq"}, {31'd0, |(m_stat & m_en)});
      probe = 1'b1;
      tick();
      probe = 1'b0;
   endtask

   // Change pad levels and let the synchroniser settle; events follow the edge rules.
   task automatic apply_pins(logic [31:0] nv);
      logic [31:0] rise, fall;
      rise   = nv & ~m_pins;
      fall   = ~nv & m_pins;
      m_stat = m_stat | (((m_esel & rise) | (~m_esel & fall)) & ~m_dir & PIN_MASK);
      m_pins = nv & PIN_MASK;
      gpio_in = nv[NP-1:0];
      idle(SS + 2);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          op, off, sel;
      logic [31:0] a, dfm, exp;

      model_reset();
      m_pins = '0;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;

      // Reset state and passthrough
      check_pins("reset");
      rd(ra(0), 32'h0, "rst_dir");
      rd(ra(1), 32'h0, "rst_out");
      rd(ra(2), 32'h0, "rst_in");
      rd(ra(3), 32'h0, "rst_irq_en");
      rd(ra(4), 32'h0, "rst_irq_stat");
      rd_dfm(32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "miss_passthru");

      // Direction and output
      wr(ra(0), 32'h0000_00FF, 1'b0);
      wr(ra(1), 32'hFFFF_FFFF, 1'b0);
      push(K_OE, "dir_oe_const", 32'h0000_00FF);
      check_pins("dir_out");
      rd(ra(1), 32'hFFFF_FFFF, "out_readback");

      // Rising edge on pin 4 through the synchroniser
      wr(ra(0), 32'h0, 1'b0);
      wr(ra(5), 32'h10, 1'b0);
      wr(ra(3), 32'h10, 1'b0);
      gpio_in = 32'h10;
      m_pins  = 32'h10;
      for (int c = 0; c < SS; c++) begin
         push(K_IRQ, "edge_irq_pre", 32'h0);
         rd(ra(2), 32'h0, "edge_in_pre");
      end
      push(K_IRQ, "edge_irq_sync", 32'h0);
      rd(ra(2), 32'h10, "edge_in_sync");
      push(K_IRQ, "edge_irq_set", 32'h1);
      rd(ra(4), 32'h10, "edge_stat");
      m_stat = 32'h10;
      wr(ra(4), 32'h10, 1'b0);
      check_pins("w1c");
      rd(ra(4), 32'h0, "w1c_stat");

      // Clear and new event on the same bit in the same cycle
      apply_pins(32'h0);
      gpio_in = 32'h10;
      m_pins  = 32'h10;
      idle(SS);
      wr(ra(4), 32'h10, 1'b0);
      m_stat = m_stat | 32'h10;
      push(K_IRQ, "w1c_vs_set_irq", 32'h1);
      rd(ra(4), 32'h10, "w1c_vs_set");
      wr(ra(4), 32'h10, 1'b0);

      // Output pins never raise events
      wr(ra(0), 32'h20, 1'b0);
      wr(ra(5), 32'h30, 1'b0);
      wr(ra(3), 32'h30, 1'b0);
      apply_pins(m_pins | 32'h20);
      push(K_IRQ, "outpin_irq", 32'h0);
      rd(ra(4), 32'h0, "outpin_stat");
      wr(ra(0), 32'h0, 1'b0);

      // Set/clear offsets
      wr(ra(1), 32'h0F, 1'b0);
      wr(ra(6), 32'hF0, 1'b0);
      rd(ra(1), SETCLR ? 32'hFF : 32'h0F, "out_set");
      wr(ra(7), 32'h03, 1'b0);
      rd(ra(1), SETCLR ? 32'hFC : 32'h0F, "out_clr");
      rd(ra(6), 32'h0, "setclr_read0");
      rd(ra(7), 32'h0, "setclr_read1");

      // Randomized bus and pin traffic
      for (int i = 0; i < 150; i++) begin
         op  = $urandom_range(0, 9);
         off = $urandom_range(0, 7);
         sel = $urandom_range(0, 9);
         a   = ra(off);
         if (sel == 8) a = a + 32'($urandom_range(1, 3));
         else if (sel == 9) a = a ^ (32'd1 << $urandom_range(5, 31));
         if (op <= 4) begin
            wr(a, $urandom, 1'($urandom_range(0, 1)));
            check_pins("rand_pins");
         end else if (op <= 8) begin
            dfm = $urandom;
            exp = is_hit(a) ? model_reg(int'(a[4:2])) : dfm;
            rd_dfm(a, dfm, exp, "rand_rd");
         end else begin
            apply_pins($urandom);
            check_pins("rand_irq");
         end
      end

      // Pins held high through reset release: warm-up masks the startup edge
      rst = 1'b1;
      gpio_in = '1;
      m_pins  = PIN_MASK;
      model_reset();
      idle(3);
      rst = 1'b0;
      wr(ra(5), 32'hFFFF_FFFF, 1'b0);
      wr(ra(3), 32'hFFFF_FFFF, 1'b0);
      idle(SS + 2);
      push(K_IRQ, "warm_irq", 32'h0);
      rd(ra(4), 32'h0, "warm_stat");
      rd(ra(2), PIN_MASK, "warm_in");

      // Raise irq, then reset asynchronously mid-cycle
      apply_pins(PIN_MASK & ~32'h1);
      apply_pins(PIN_MASK);
      check_pins("irq_up");
      wr(ra(0), 32'hF0, 1'b0);
      wr(ra(1), 32'hF0, 1'b0);
      check_pins("pre_rst");
      #2;
      rst = 1'b1;
      model_reset();
      push(K_IRQ, "async_rst_irq", 32'h0);
      push(K_OE, "async_rst_oe", 32'h0);
      push(K_OUT, "async_rst_out", 32'h0);
      probe = 1'b1;
      tick();
      probe = 1'b0;
      rst = 1'b0;
      idle(SS + 3);
      rd(ra(4), 32'h0, "post_rst_stat");

      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
